// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter/sequencer for a single-port 1024x32 data memory.
// Optional requester-1 lock is enabled by defining DMEM_ARB_LOCK_EN.
module dmem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    input  logic              m1_lock,
    output logic [DATA_W-1:0] rd_data,
    output logic              err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Handshake: a requester holds req/we/addr/wdata until it sees gnt in the same
    // cycle; its single-cycle rvalid follows two cycles later with rd_data and err.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    localparam logic [ADDR_W-1:0] MEM_WORDS_A = ADDR_W'(MEM_WORDS);

    state_e            state_q, state_d;
    logic              rr_m1_q, rr_m1_d;
    logic              hold_we_q, hold_we_d;
    logic              hold_owner_q, hold_owner_d;
    logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
    logic [DATA_W-1:0] hold_wdata_q, hold_wdata_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              err_q, err_d;
    logic              pick_m1;
    logic              can_grant;
    logic              in_range;

`ifdef DMEM_ARB_LOCK_EN
    logic lock_q, lock_d;
`else
    logic unused_m1_lock;
    assign unused_m1_lock = m1_lock;
`endif

    assign in_range = (hold_addr_q >> 2) < MEM_WORDS_A;

    // DONE doubles as IDLE, so a new grant can overlap the completion pulse.
    always_comb begin : arb_comb
        can_grant = (state_q != ACCESS);
        if (m0_req && m1_req) begin
            pick_m1 = rr_m1_q;
        end else begin
            pick_m1 = m1_req;
        end
`ifdef DMEM_ARB_LOCK_EN
        if (lock_q && m1_req) begin
            pick_m1 = 1'b1;
        end
`endif
        m0_gnt = can_grant && m0_req && !pick_m1;
        m1_gnt = can_grant && m1_req && pick_m1;
    end

    always_comb begin : next_comb
        state_d      = state_q;
        rr_m1_d      = rr_m1_q;
        hold_we_d    = hold_we_q;
        hold_owner_d = hold_owner_q;
        hold_addr_d  = hold_addr_q;
        hold_wdata_d = hold_wdata_q;
        rd_data_d    = rd_data_q;
        err_d        = err_q;
`ifdef DMEM_ARB_LOCK_EN
        lock_d       = lock_q;
`endif
        case (state_q)
            IDLE, DONE: state_d = (m0_gnt || m1_gnt) ? ACCESS : IDLE;
            ACCESS: begin
                state_d   = DONE;
                rd_data_d = (!hold_we_q && in_range) ? mem_rdata : '0;
                err_d     = !in_range;
            end
            default: state_d = IDLE;
        endcase
        if (m0_gnt || m1_gnt) begin
            hold_owner_d = m1_gnt;
            hold_we_d    = m1_gnt ? m1_we : m0_we;
            hold_addr_d  = m1_gnt ? m1_addr : m0_addr;
            hold_wdata_d = m1_gnt ? m1_wdata : m0_wdata;
            rr_m1_d      = m0_gnt;
`ifdef DMEM_ARB_LOCK_EN
            if (m1_gnt) begin
                lock_d = m1_lock;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rr_m1_q      <= 1'b0;
            hold_we_q    <= 1'b0;
            hold_owner_q <= 1'b0;
            hold_addr_q  <= '0;
            hold_wdata_q <= '0;
            rd_data_q    <= '0;
            err_q        <= 1'b0;
`ifdef DMEM_ARB_LOCK_EN
            lock_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            rr_m1_q      <= rr_m1_d;
            hold_we_q    <= hold_we_d;
            hold_owner_q <= hold_owner_d;
            hold_addr_q  <= hold_addr_d;
            hold_wdata_q <= hold_wdata_d;
            rd_data_q    <= rd_data_d;
            err_q        <= err_d;
`ifdef DMEM_ARB_LOCK_EN
            lock_q       <= lock_d;
`endif
        end
    end

    assign mem_we    = (state_q == ACCESS) && hold_we_q && in_range;
    assign mem_addr  = hold_addr_q;
    assign mem_wdata = hold_wdata_q;
    assign m0_rvalid = (state_q == DONE) && !hold_owner_q;
    assign m1_rvalid = (state_q == DONE) && hold_owner_q;
    assign err       = (state_q == DONE) && err_q;
    assign rd_data   = rd_data_q;

endmodule
